// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the 15-unit vending controller.
// Coin and change codes match the coin-acceptor and actuator wiring.
package vending_machine_pkg;

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_5      = 2'b01;
  localparam logic [1:0] COIN_10     = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  localparam int unsigned PRICE = 32'd15;

endpackage

// File: rtl/vending_machine_if.sv
// Coin-acceptor input and dispense/change actuator outputs of the vending controller.
// The master side drives coins; the slave side (the controller) drives the pulses.
interface vending_machine_if;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  modport master (output in, input out, input change);
  modport slave  (input in, output out, output change);
endinterface

// File: rtl/vending_machine_chk.sv
// Simulation-only invariants for the vending controller outputs.
// A dispense pulse must always be caused by a coin sampled on the edge before it.
module vending_machine_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] coin,
  input logic       out,
  input logic [1:0] change
);

  a_out_needs_event: assert property (
    @(posedge clk) disable iff (rst) out |-> ($past(coin) != 2'b00)
  ) else $error("vending_machine: dispense pulse without a coin event");

  a_change_legal: assert property (
    @(posedge clk) disable iff (rst) change != 2'b11
  ) else $error("vending_machine: illegal change code 11");

endmodule

// File: rtl/vending_machine.sv
// Moore-style vending controller: credit held in a 2-bit state, one event per edge,
// dispense and change emitted as registered one-cycle pulses.
module vending_machine
  import vending_machine_pkg::*;
(
  input logic               clk,
  input logic               rst,
  vending_machine_if.slave  bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_out;
  logic       w_out_nxt;
  logic [1:0] r_change;
  logic [1:0] w_change_nxt;

  // Reset wins over any coin on the same edge, discarding held credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S0;
      r_out    <= 1'b0;
      r_change <= CHG_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_change <= w_change_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S0;
    case (r_state)
      S0: begin
        case (bus.in)
          COIN_5:  w_state_nxt = S5;
          COIN_10: w_state_nxt = S10;
          default: w_state_nxt = S0;
        endcase
      end
      S5: begin
        case (bus.in)
          COIN_NONE: w_state_nxt = S5;
          COIN_5:    w_state_nxt = S10;
          default:   w_state_nxt = S0;
        endcase
      end
      S10: begin
        case (bus.in)
          COIN_NONE: w_state_nxt = S10;
          default:   w_state_nxt = S0;
        endcase
      end
      default: w_state_nxt = S0;
    endcase
  end

  // Any sale or refund returns to S0, so outputs only pulse on the completing event.
  always_comb begin
    w_out_nxt    = 1'b0;
    w_change_nxt = CHG_NONE;
    case (r_state)
      S5: begin
        case (bus.in)
          COIN_10:     w_out_nxt    = 1'b1;
          COIN_CANCEL: w_change_nxt = CHG_5;
          default:     w_out_nxt    = 1'b0;
        endcase
      end
      S10: begin
        case (bus.in)
          COIN_5: w_out_nxt = 1'b1;
          COIN_10: begin
            w_out_nxt    = 1'b1;
            w_change_nxt = CHG_5;
          end
          COIN_CANCEL: w_change_nxt = CHG_10;
          default:     w_out_nxt    = 1'b0;
        endcase
      end
      default: w_out_nxt = 1'b0;
    endcase
  end

  assign bus.out    = r_out;
  assign bus.change = r_change;

`ifndef SYNTHESIS
  vending_machine_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .coin   (bus.in),
    .out    (r_out),
    .change (r_change)
  );
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: a credit-arithmetic model queues the expected
// out/change/state for each edge, compared one cycle-phase after the edge.
module tb_vending_machine;
  import vending_machine_pkg::*;

  logic clk;
  logic rst;
  vending_machine_if vif ();

  vending_machine dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       o;
    logic [1:0] c;
    logic [1:0] s;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_credit = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model works in credit units, independent of the state encoding.
  task automatic model_step(input logic r, input logic [1:0] coin, output exp_t e);
    int total;
    e.o = 1'b0;
    e.c = 2'b00;
    if (r) begin
      m_credit = 0;
    end else if (coin == 2'b11) begin
      e.c = 2'(m_credit / 5);
      m_credit = 0;
    end else if (coin != 2'b00) begin
      total = m_credit + 5 * int'(coin);
      if (total >= 15) begin
        e.o = 1'b1;
        e.c = 2'((total - 15) / 5);
        m_credit = 0;
      end else begin
        m_credit = total;
      end
    end
    e.s = 2'(m_credit / 5);
  endtask

  task automatic apply(input logic r, input logic [1:0] coin, input string tag);
    exp_t e;
    exp_t got;
    model_step(r, coin, e);
    e.tag = tag;
    sb_q.push_back(e);
    rst    = r;
    vif.in = coin;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 8'd1, 8'd0);
    end else begin
      got = sb_q.pop_front();
      check_eq({got.tag, ".out"},    {7'd0, vif.out},       {7'd0, got.o});
      check_eq({got.tag, ".change"}, {6'd0, vif.change},    {6'd0, got.c});
      check_eq({got.tag, ".state"},  {6'd0, dut.r_state},   {6'd0, got.s});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    vif.in = 2'b01;
    apply(1'b1, 2'b01, "rst_hold0");
    apply(1'b1, 2'b01, "rst_hold1");

    for (int i = 0; i < 4; i++) apply(1'b0, 2'b01, $sformatf("five_held%0d", i));
    apply(1'b0, 2'b11, "cancel_s5");

    apply(1'b0, 2'b10, "ten_ten_a");
    apply(1'b0, 2'b10, "ten_ten_b");
    apply(1'b0, 2'b00, "idle_after");

    apply(1'b0, 2'b01, "refund5_a");
    apply(1'b0, 2'b11, "refund5_b");
    apply(1'b0, 2'b10, "refund10_a");
    apply(1'b0, 2'b00, "idle_s10");
    apply(1'b0, 2'b11, "refund10_b");

    apply(1'b0, 2'b10, "b2b_a0");
    apply(1'b0, 2'b01, "b2b_a1");
    apply(1'b0, 2'b10, "b2b_a2");
    apply(1'b0, 2'b01, "b2b_a3");
    apply(1'b0, 2'b10, "b2b_b0");
    apply(1'b0, 2'b01, "b2b_b1");
    apply(1'b0, 2'b10, "b2b_b2");
    apply(1'b0, 2'b10, "b2b_b3");

    apply(1'b0, 2'b10, "s10_then_rst");
    apply(1'b1, 2'b10, "rst_with_ten");
    apply(1'b0, 2'b01, "five_after_rst");
    apply(1'b0, 2'b00, "idle_s5");
    apply(1'b0, 2'b11, "clear");

    for (int i = 0; i < 60; i++) begin
      apply(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
            $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
